// File: rtl/memory_stage_if.sv
// Bundle of the execute-side, data-memory and writeback signals of memory_stage.
// The slave modport is the stage's own view; the master modport drives it.
interface memory_stage_if;
    logic        IN_VALID;
    logic [31:0] IR;
    logic [31:0] ALU_RESULT;
    logic [31:0] RS_2;
    logic [31:0] PC_COUNT;
    logic        MEM_STALL;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [31:0] DMEM_WDATA;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_ACK;
    logic        WB_VALID;
    logic        MEM_ERR;
    logic        MEM_MISALIGN;
    logic [31:0] WB_IR;
    logic [31:0] WB_PC;
    logic [31:0] WB_ALU;
    logic [31:0] WB_LOAD_DATA;

    modport slave (
        input  IN_VALID, IR, ALU_RESULT, RS_2, PC_COUNT, DMEM_RDATA, DMEM_ACK,
        output MEM_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
               WB_VALID, MEM_ERR, MEM_MISALIGN, WB_IR, WB_PC, WB_ALU, WB_LOAD_DATA
    );

    modport master (
        output IN_VALID, IR, ALU_RESULT, RS_2, PC_COUNT, DMEM_RDATA, DMEM_ACK,
        input  MEM_STALL, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
               WB_VALID, MEM_ERR, MEM_MISALIGN, WB_IR, WB_PC, WB_ALU, WB_LOAD_DATA
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: one outstanding data-memory access with timeout abort.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of masking the low address bits.
module memory_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          MEM_CLK,
    input  logic          MEM_RST_N,
    memory_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    // Abort fires in the MAX_WAIT-th ACCESS cycle, so the counter compares against MAX_WAIT-1.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [7:0]  wait_cnt_r, wait_cnt_s;
    logic [31:0] hold_ir_r, hold_ir_s, hold_pc_r, hold_pc_s, hold_alu_r, hold_alu_s;
    logic        dmem_req_r, dmem_req_s, dmem_we_r, dmem_we_s;
    logic [31:0] dmem_addr_r, dmem_addr_s, dmem_wdata_r, dmem_wdata_s;
    logic [3:0]  dmem_be_r, dmem_be_s;
    logic        wb_valid_r, wb_valid_s, mem_err_r, mem_err_s, mem_misalign_r, mem_misalign_s;
    logic [31:0] wb_ir_r, wb_ir_s, wb_pc_r, wb_pc_s, wb_alu_r, wb_alu_s;
    logic [31:0] wb_load_data_r, wb_load_data_s;
    logic        in_load_s, in_store_s, in_misalign_s, hold_load_s;

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b00:   store_be = 4'b0001 << addr;
            2'b01:   store_be = addr[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] rs2);
        case (funct3[1:0])
            2'b00:   store_data = {4{rs2[7:0]}};
            2'b01:   store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] funct3, input logic [1:0] addr,
                                                input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (addr)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            3'b000:  load_format = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_format = {{16{half_v[15]}}, half_v};
            3'b100:  load_format = {24'h000000, byte_v};
            3'b101:  load_format = {16'h0000, half_v};
            default: load_format = rdata;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    assign in_misalign_s    = misaligned(bus.IR[14:12], bus.ALU_RESULT[1:0]);
    assign bus.MEM_MISALIGN = mem_misalign_r;
`else
    assign in_misalign_s    = 1'b0;
    assign bus.MEM_MISALIGN = 1'b0;
`endif

    assign in_load_s   = (bus.IR[6:0] == OP_LOAD);
    assign in_store_s  = (bus.IR[6:0] == OP_STORE);
    assign hold_load_s = (hold_ir_r[6:0] == OP_LOAD);

    // Next-state and next-output logic of the IDLE/ACCESS handshake
    always_comb begin
        state_s        = state_r;
        wait_cnt_s     = wait_cnt_r;
        hold_ir_s      = hold_ir_r;
        hold_pc_s      = hold_pc_r;
        hold_alu_s     = hold_alu_r;
        dmem_req_s     = dmem_req_r;
        dmem_we_s      = dmem_we_r;
        dmem_addr_s    = dmem_addr_r;
        dmem_be_s      = dmem_be_r;
        dmem_wdata_s   = dmem_wdata_r;
        wb_valid_s     = 1'b0;
        mem_err_s      = 1'b0;
        mem_misalign_s = 1'b0;
        wb_ir_s        = wb_ir_r;
        wb_pc_s        = wb_pc_r;
        wb_alu_s       = wb_alu_r;
        wb_load_data_s = wb_load_data_r;
        case (state_r)
            IDLE: begin
                if (bus.IN_VALID && (!(in_load_s || in_store_s) || in_misalign_s)) begin
                    wb_valid_s     = 1'b1;
                    mem_misalign_s = in_misalign_s;
                    wb_ir_s        = bus.IR;
                    wb_pc_s        = bus.PC_COUNT;
                    wb_alu_s       = bus.ALU_RESULT;
                    wb_load_data_s = 32'h00000000;
                end else if (bus.IN_VALID) begin
                    state_s      = ACCESS;
                    wait_cnt_s   = 8'd0;
                    hold_ir_s    = bus.IR;
                    hold_pc_s    = bus.PC_COUNT;
                    hold_alu_s   = bus.ALU_RESULT;
                    dmem_req_s   = 1'b1;
                    dmem_we_s    = in_store_s;
                    dmem_addr_s  = {bus.ALU_RESULT[31:2], 2'b00};
                    dmem_be_s    = in_store_s ? store_be(bus.IR[14:12], bus.ALU_RESULT[1:0]) : 4'b1111;
                    dmem_wdata_s = in_store_s ? store_data(bus.IR[14:12], bus.RS_2) : 32'h00000000;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (bus.DMEM_ACK || (wait_cnt_r == LAST_WAIT)) begin
                    state_s      = IDLE;
                    dmem_req_s   = 1'b0;
                    dmem_we_s    = 1'b0;
                    dmem_addr_s  = 32'h00000000;
                    dmem_be_s    = 4'b0000;
                    dmem_wdata_s = 32'h00000000;
                    wb_valid_s   = 1'b1;
                    wb_ir_s      = hold_ir_r;
                    wb_pc_s      = hold_pc_r;
                    wb_alu_s     = hold_alu_r;
                    if (bus.DMEM_ACK) begin
                        wb_load_data_s = hold_load_s ?
                            load_format(hold_ir_r[14:12], hold_alu_r[1:0], bus.DMEM_RDATA) : 32'h00000000;
                    end else begin
                        mem_err_s      = 1'b1;
                        wb_load_data_s = 32'h00000000;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, hold and output registers; reset clears everything at once
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            state_r        <= IDLE;
            wait_cnt_r     <= 8'd0;
            hold_ir_r      <= 32'h00000000;
            hold_pc_r      <= 32'h00000000;
            hold_alu_r     <= 32'h00000000;
            dmem_req_r     <= 1'b0;
            dmem_we_r      <= 1'b0;
            dmem_addr_r    <= 32'h00000000;
            dmem_be_r      <= 4'b0000;
            dmem_wdata_r   <= 32'h00000000;
            wb_valid_r     <= 1'b0;
            mem_err_r      <= 1'b0;
            mem_misalign_r <= 1'b0;
            wb_ir_r        <= 32'h00000000;
            wb_pc_r        <= 32'h00000000;
            wb_alu_r       <= 32'h00000000;
            wb_load_data_r <= 32'h00000000;
        end else begin
            state_r        <= state_s;
            wait_cnt_r     <= wait_cnt_s;
            hold_ir_r      <= hold_ir_s;
            hold_pc_r      <= hold_pc_s;
            hold_alu_r     <= hold_alu_s;
            dmem_req_r     <= dmem_req_s;
            dmem_we_r      <= dmem_we_s;
            dmem_addr_r    <= dmem_addr_s;
            dmem_be_r      <= dmem_be_s;
            dmem_wdata_r   <= dmem_wdata_s;
            wb_valid_r     <= wb_valid_s;
            mem_err_r      <= mem_err_s;
            mem_misalign_r <= mem_misalign_s;
            wb_ir_r        <= wb_ir_s;
            wb_pc_r        <= wb_pc_s;
            wb_alu_r       <= wb_alu_s;
            wb_load_data_r <= wb_load_data_s;
        end
    end

    // The request register is high exactly while in ACCESS, so it doubles as the stall
    assign bus.MEM_STALL    = dmem_req_r;
    assign bus.DMEM_REQ     = dmem_req_r;
    assign bus.DMEM_WE      = dmem_we_r;
    assign bus.DMEM_ADDR    = dmem_addr_r;
    assign bus.DMEM_BE      = dmem_be_r;
    assign bus.DMEM_WDATA   = dmem_wdata_r;
    assign bus.WB_VALID     = wb_valid_r;
    assign bus.MEM_ERR      = mem_err_r;
    assign bus.WB_IR        = wb_ir_r;
    assign bus.WB_PC        = wb_pc_r;
    assign bus.WB_ALU       = wb_alu_r;
    assign bus.WB_LOAD_DATA = wb_load_data_r;
endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (default build, MAX_WAIT=15).
module tb_memory_stage;
    logic mem_clk;
    logic mem_rst_n;
    int   n_cmp;
    int   n_err;
    int   stalls;
    logic done;
    logic stable;
    logic wbv_seen;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    memory_stage_if bus ();

    memory_stage #(.MAX_WAIT(15)) dut (
        .MEM_CLK   (mem_clk),
        .MEM_RST_N (mem_rst_n),
        .bus       (bus)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    function automatic logic [31:0] mk_ir(input logic [2:0] funct3, input logic [6:0] opcode);
        mk_ir = {17'h00000, funct3, 5'd10, opcode};
    endfunction

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one load/store, ack it in ACCESS cycle ack_at (0 = never), return at the completion cycle.
    task automatic mem_op(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int ack_at, input logic busy);
        bus.IN_VALID   = 1'b1;
        bus.IR         = ir;
        bus.ALU_RESULT = addr;
        bus.RS_2       = rs2;
        bus.PC_COUNT   = 32'h00000400;
        tick();
        bus.IR         = mk_ir(3'b000, 7'b0110011);
        bus.ALU_RESULT = 32'hDEADBEEF;
        bus.RS_2       = 32'h55555555;
        bus.IN_VALID   = busy;
        stalls   = 0;
        done     = 1'b0;
        stable   = 1'b1;
        wbv_seen = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (!bus.MEM_STALL) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls == 1) begin
                    cap_addr  = bus.DMEM_ADDR;
                    cap_be    = bus.DMEM_BE;
                    cap_wdata = bus.DMEM_WDATA;
                    cap_we    = bus.DMEM_WE;
                end else if (bus.DMEM_ADDR !== cap_addr || bus.DMEM_BE !== cap_be ||
                             bus.DMEM_WDATA !== cap_wdata || bus.DMEM_WE !== cap_we ||
                             bus.DMEM_REQ !== 1'b1) begin
                    stable = 1'b0;
                end
                if (bus.WB_VALID) wbv_seen = 1'b1;
                bus.DMEM_ACK    = (stalls == ack_at);
                bus.DMEM_RDATA  = rdata;
                if (stalls == ack_at) bus.IN_VALID = 1'b0;
                tick();
            end
        end
        bus.DMEM_ACK = 1'b0;
        bus.IN_VALID = 1'b0;
        check("access_bound", {31'd0, done}, 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mem_rst_n      = 1'b0;
        bus.IN_VALID   = 1'b0;
        bus.IR         = 32'h0;
        bus.ALU_RESULT = 32'h0;
        bus.RS_2       = 32'h0;
        bus.PC_COUNT   = 32'h0;
        bus.DMEM_RDATA = 32'h0;
        bus.DMEM_ACK   = 1'b0;
        tick();
        tick();
        check("rst_wb_valid", {31'd0, bus.WB_VALID}, 32'd0);
        check("rst_req", {31'd0, bus.DMEM_REQ}, 32'd0);
        check("rst_stall", {31'd0, bus.MEM_STALL}, 32'd0);
        check("rst_wb_ir", bus.WB_IR, 32'h0);

        // ADD accepted on the first edge after reset release
        mem_rst_n      = 1'b1;
        bus.IN_VALID   = 1'b1;
        bus.IR         = 32'h00B50533;
        bus.ALU_RESULT = 32'h12345678;
        bus.PC_COUNT   = 32'h00000100;
        check("add_no_req_pre", {31'd0, bus.DMEM_REQ}, 32'd0);
        tick();
        bus.IN_VALID = 1'b0;
        check("add_wb_valid", {31'd0, bus.WB_VALID}, 32'd1);
        check("add_wb_alu", bus.WB_ALU, 32'h12345678);
        check("add_wb_ir", bus.WB_IR, 32'h00B50533);
        check("add_wb_pc", bus.WB_PC, 32'h00000100);
        check("add_load_data", bus.WB_LOAD_DATA, 32'h0);
        check("add_no_req", {31'd0, bus.DMEM_REQ}, 32'd0);
        tick();
        check("add_pulse_end", {31'd0, bus.WB_VALID}, 32'd0);

        // SB at 0x103, ACK in third ACCESS cycle, IN_VALID held high and ignored meanwhile
        mem_op(mk_ir(3'b000, 7'b0100011), 32'h00000103, 32'h000000AB, 32'h0, 3, 1'b1);
        check("sb_addr", cap_addr, 32'h00000100);
        check("sb_be", {28'd0, cap_be}, 32'h8);
        check("sb_wdata", cap_wdata, 32'hABABABAB);
        check("sb_we", {31'd0, cap_we}, 32'd1);
        check("sb_stall_cycles", stalls, 32'd3);
        check("sb_stable", {31'd0, stable}, 32'd1);
        check("sb_no_early_wb", {31'd0, wbv_seen}, 32'd0);
        check("sb_wb_valid", {31'd0, bus.WB_VALID}, 32'd1);
        check("sb_wb_alu", bus.WB_ALU, 32'h00000103);
        check("sb_load_data", bus.WB_LOAD_DATA, 32'h0);
        check("sb_err", {31'd0, bus.MEM_ERR}, 32'd0);
        check("sb_req_drop", {31'd0, bus.DMEM_REQ}, 32'd0);
        tick();
        check("sb_pulse_end", {31'd0, bus.WB_VALID}, 32'd0);

        // Loads with ACK in the first ACCESS cycle
        mem_op(mk_ir(3'b000, 7'b0000011), 32'h00000002, 32'h0, 32'h00800000, 1, 1'b0);
        check("lb_be", {28'd0, cap_be}, 32'hF);
        check("lb_we", {31'd0, cap_we}, 32'd0);
        check("lb_addr", cap_addr, 32'h0);
        check("lb_data", bus.WB_LOAD_DATA, 32'hFFFFFF80);
        check("lb_stalls", stalls, 32'd1);
        mem_op(mk_ir(3'b100, 7'b0000011), 32'h00000002, 32'h0, 32'h00800000, 1, 1'b0);
        check("lbu_data", bus.WB_LOAD_DATA, 32'h00000080);
        mem_op(mk_ir(3'b001, 7'b0000011), 32'h00000002, 32'h0, 32'h80011234, 2, 1'b0);
        check("lh_data", bus.WB_LOAD_DATA, 32'hFFFF8001);
        mem_op(mk_ir(3'b101, 7'b0000011), 32'h00000000, 32'h0, 32'h80019234, 1, 1'b0);
        check("lhu_data", bus.WB_LOAD_DATA, 32'h00009234);

        // SH to the upper half
        mem_op(mk_ir(3'b001, 7'b0100011), 32'h00000302, 32'h5678CDEF, 32'h0, 1, 1'b0);
        check("sh_addr", cap_addr, 32'h00000300);
        check("sh_be", {28'd0, cap_be}, 32'hC);
        check("sh_wdata", cap_wdata, 32'hCDEFCDEF);

        // LW with no ACK: 15 ACCESS cycles then abort
        mem_op(mk_ir(3'b010, 7'b0000011), 32'h00000200, 32'h0, 32'hCAFEF00D, 0, 1'b0);
        check("to_stalls", stalls, 32'd15);
        check("to_wb_valid", {31'd0, bus.WB_VALID}, 32'd1);
        check("to_err", {31'd0, bus.MEM_ERR}, 32'd1);
        check("to_load_data", bus.WB_LOAD_DATA, 32'h0);
        tick();
        check("to_err_pulse", {31'd0, bus.MEM_ERR}, 32'd0);

        // LW with ACK in cycle 15: ACK wins over timeout
        mem_op(mk_ir(3'b010, 7'b0000011), 32'h00000204, 32'h0, 32'hCAFEF00D, 15, 1'b0);
        check("ack15_stalls", stalls, 32'd15);
        check("ack15_err", {31'd0, bus.MEM_ERR}, 32'd0);
        check("ack15_wb_valid", {31'd0, bus.WB_VALID}, 32'd1);
        check("ack15_data", bus.WB_LOAD_DATA, 32'hCAFEF00D);

        // SW at 0x102
        mem_op(mk_ir(3'b010, 7'b0100011), 32'h00000102, 32'h11223344, 32'h0, 1, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("sw_mis_stalls", stalls, 32'd0);
        check("sw_mis_flag", {31'd0, bus.MEM_MISALIGN}, 32'd1);
        check("sw_mis_wb_valid", {31'd0, bus.WB_VALID}, 32'd1);
`else
        check("sw_addr", cap_addr, 32'h00000100);
        check("sw_be", {28'd0, cap_be}, 32'hF);
        check("sw_misalign", {31'd0, bus.MEM_MISALIGN}, 32'd0);
`endif

        // Reset in the second ACCESS cycle
        bus.IN_VALID   = 1'b1;
        bus.IR         = mk_ir(3'b010, 7'b0000011);
        bus.ALU_RESULT = 32'h00000300;
        tick();
        bus.IN_VALID = 1'b0;
        tick();
        check("rst2_req_before", {31'd0, bus.DMEM_REQ}, 32'd1);
        mem_rst_n = 1'b0;
        #1;
        check("rst2_req", {31'd0, bus.DMEM_REQ}, 32'd0);
        check("rst2_stall", {31'd0, bus.MEM_STALL}, 32'd0);
        check("rst2_be", {28'd0, bus.DMEM_BE}, 32'h0);
        check("rst2_wb_alu", bus.WB_ALU, 32'h0);
        tick();
        check("rst2_no_wb", {31'd0, bus.WB_VALID}, 32'd0);
        mem_rst_n      = 1'b1;
        bus.IN_VALID   = 1'b1;
        bus.IR         = 32'h00B50533;
        bus.ALU_RESULT = 32'h0BADC0DE;
        tick();
        bus.IN_VALID = 1'b0;
        check("post_rst_wb_valid", {31'd0, bus.WB_VALID}, 32'd1);
        check("post_rst_wb_alu", bus.WB_ALU, 32'h0BADC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
